// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks: parity encodings,
// receiver state encoding and the baud-tick divisor.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  function automatic int calc_div(input int clock, input int baud, input int ovs);
    return clock / (baud * ovs);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; read data is the head entry while
// not empty and zero otherwise. A write while full is accepted only with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity,
// 1/2 stop bits, sticky error flags and a FWFT receive buffer.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a synced falling edge
// ST_START     | validating the start bit (majority 1 = glitch, back to idle)
// ST_DATA      | shifting in DATA_BITS payload bits, LSB first
// ST_PARITY    | checking the parity bit
// ST_STOP      | sampling STOP_BITS stop bits; frame verdict at the last vote
// ST_WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLOCK      = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int DIV = calc_div(CLOCK, BAUD, OVS);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVS);

  localparam logic [TW-1:0] TICK_TC   = TW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVS - 1);
  localparam logic [OW-1:0] SAMP_A    = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] SAMP_B    = OW'(OVS / 2);
  localparam logic [OW-1:0] SAMP_C    = OW'(OVS / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [OW-1:0]        os_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 commit_stb;
  logic                 commit_perr;
  logic                 commit_ferr;
  logic [7:0]           commit_data;

  logic tick;
  logic vote_pt;
  logic vote_bit;
  logic exp_par;
  logic last_bad;
  logic push;
  logic ovr_evt;
  logic fifo_empty;

  assign tick     = (tick_cnt == TICK_TC);
  assign vote_pt  = tick && (os_cnt == SAMP_C);
  assign vote_bit = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign exp_par  = (PARITY == PAR_EVEN) ? ^shreg : ~^shreg;
  assign last_bad = stop_bad | ~vote_bit;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      tick_cnt    <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      shreg       <= '0;
      par_bad     <= 1'b0;
      stop_bad    <= 1'b0;
      commit_stb  <= 1'b0;
      commit_perr <= 1'b0;
      commit_ferr <= 1'b0;
      commit_data <= '0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      commit_stb <= 1'b0;
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
        if (os_cnt == SAMP_A) samp_a <= rx_sync;
        if (os_cnt == SAMP_B) samp_b <= rx_sync;
      end

      // State changes happen at the vote point; os_cnt keeps running across
      // bit boundaries so the next vote lands mid-way through the next bit.
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= ST_START;
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
          end
        end
        ST_START: begin
          if (vote_pt) begin
            state    <= vote_bit ? ST_IDLE : ST_DATA;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
        end
        ST_DATA: begin
          if (vote_pt) begin
            shreg <= {vote_bit, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_pt) begin
            par_bad <= (vote_bit != exp_par);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vote_pt) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt     <= '0;
              commit_stb  <= 1'b1;
              commit_perr <= par_bad;
              commit_ferr <= last_bad;
              commit_data <= 8'(shreg);
              state       <= last_bad ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              stop_bad <= last_bad;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push    = commit_stb && !commit_perr && !commit_ferr;
  assign ovr_evt = push && fifo_full && !rd_en;

  // A new error event takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit_stb && commit_ferr) frame_err <= 1'b1;
      else if (clr_err)              frame_err <= 1'b0;
      if (commit_stb && commit_perr) parity_err <= 1'b1;
      else if (clr_err)              parity_err <= 1'b0;
      if (ovr_evt)                   overrun <= 1'b1;
      else if (clr_err)              overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (commit_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rd_valid = !fifo_empty;

endmodule
